// File: rtl/robo_labirinto.sv
// ============================================================================
// robo_labirinto : 8x8 maze environment for the wall-following robot.
// Optional step budget: define ROBO_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module robo_labirinto #(
  parameter logic [63:0] MAP       = 64'h0,
  parameter logic [2:0]  START_X   = 3'd0,
  parameter logic [2:0]  START_Y   = 3'd0,
  parameter logic [1:0]  START_DIR = 2'd0,
  parameter logic [2:0]  GOAL_X    = 3'd7,
  parameter logic [2:0]  GOAL_Y    = 3'd7,
  parameter int          STEP_W    = 16,
  parameter int          MAX_STEPS = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              avancar,
  input  logic              girar,
  output logic              head,
  output logic              left,
  output logic [2:0]        pos_x,
  output logic [2:0]        pos_y,
  output logic [1:0]        dir,
  output logic              done,
  output logic              colisao,
  output logic              erro,
  output logic [STEP_W-1:0] passos,
  output logic              timeout
);

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Neighbour in direction d is blocked if it leaves the grid or is a wall.
  function automatic logic cell_blocked(input logic [2:0] x, input logic [2:0] y,
                                        input logic [1:0] d);
    logic       edge_hit;
    logic [2:0] nx;
    logic [2:0] ny;
    edge_hit = 1'b0;
    nx       = x;
    ny       = y;
    case (d)
      DIR_N: begin edge_hit = (y == 3'd7); ny = y + 3'd1; end
      DIR_E: begin edge_hit = (x == 3'd7); nx = x + 3'd1; end
      DIR_S: begin edge_hit = (y == 3'd0); ny = y - 3'd1; end
      DIR_W: begin edge_hit = (x == 3'd0); nx = x - 3'd1; end
    endcase
    return edge_hit | MAP[{ny, nx}];
  endfunction

  logic [2:0]        next_x;
  logic [2:0]        next_y;
  logic              frozen;
  logic              executed;
  logic [STEP_W-1:0] passos_inc;

  assign head = cell_blocked(pos_x, pos_y, dir);
  assign left = cell_blocked(pos_x, pos_y, dir - 2'd1);
  assign done = (pos_x == GOAL_X) && (pos_y == GOAL_Y);

  assign frozen     = done | timeout;
  assign executed   = !frozen && ((avancar && !girar && !head) || (girar && !avancar));
  assign passos_inc = (&passos) ? passos : passos + STEP_W'(1);

  always_comb begin
    next_x = pos_x;
    next_y = pos_y;
    case (dir)
      DIR_N: next_y = pos_y + 3'd1;
      DIR_E: next_x = pos_x + 3'd1;
      DIR_S: next_y = pos_y - 3'd1;
      DIR_W: next_x = pos_x - 3'd1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_x   <= START_X;
      pos_y   <= START_Y;
      dir     <= START_DIR;
      colisao <= 1'b0;
      erro    <= 1'b0;
      passos  <= '0;
    end else if (!frozen) begin
      if (avancar && girar) begin
        erro <= 1'b1;
      end else if (avancar) begin
        if (head) begin
          colisao <= 1'b1;
        end else begin
          pos_x <= next_x;
          pos_y <= next_y;
        end
      end else if (girar) begin
        dir <= dir + 2'd1;
      end
      if (executed) passos <= passos_inc;
    end
  end

`ifdef ROBO_TIMEOUT_EN
  localparam logic [STEP_W-1:0] MAX_W = STEP_W'(MAX_STEPS);

  logic timeout_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (executed && (passos_inc == MAX_W)) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_budget;
  assign unused_budget = (MAX_STEPS != 0);
  assign timeout       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_robo_labirinto.sv
// ============================================================================
// tb_robo_labirinto : scoreboard bench for robo_labirinto (two configurations).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_robo_labirinto;

`ifdef ROBO_TIMEOUT_EN
  localparam int TMO = 1;
`else
  localparam int TMO = 0;
`endif

  logic clock;
  int   cyc;

  // Instance A: open map, goal (7,7), 16-bit counter
  logic        rst_a, av_a, gi_a;
  logic        ah, al, adn, ac, ae, at;
  logic [2:0]  ax, ay;
  logic [1:0]  ad;
  logic [15:0] ap;

  // Instance B: wall at (1,0), goal (0,2), 3-bit counter, budget 5
  logic        rst_b, av_b, gi_b;
  logic        bh, bl, bdn, bc, be, bt;
  logic [2:0]  bx, by;
  logic [1:0]  bd;
  logic [2:0]  bp;

  robo_labirinto dut_a (
    .clock(clock), .reset(rst_a), .avancar(av_a), .girar(gi_a),
    .head(ah), .left(al), .pos_x(ax), .pos_y(ay), .dir(ad), .done(adn),
    .colisao(ac), .erro(ae), .passos(ap), .timeout(at)
  );

  robo_labirinto #(
    .MAP(64'h2), .GOAL_X(3'd0), .GOAL_Y(3'd2), .STEP_W(3), .MAX_STEPS(5)
  ) dut_b (
    .clock(clock), .reset(rst_b), .avancar(av_b), .girar(gi_b),
    .head(bh), .left(bl), .pos_x(bx), .pos_y(by), .dir(bd), .done(bdn),
    .colisao(bc), .erro(be), .passos(bp), .timeout(bt)
  );

  typedef struct packed {
    logic        sel;
    int          due;
    logic [31:0] v;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Layout: x[31:29] y[28:26] dir[25:24] head left done colisao erro timeout, passos[15:0]
  function automatic logic [31:0] mk(input int x, input int y, input int d, input int h,
                                     input int l, input int dn, input int c, input int e,
                                     input int t, input int p);
    return {x[2:0], y[2:0], d[1:0], h[0], l[0], dn[0], c[0], e[0], t[0], 2'b00, p[15:0]};
  endfunction

  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t        e;
      string       nm;
      logic [31:0] got;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.sel == 1'b0)
        got = {ax, ay, ad, ah, al, adn, ac, ae, at, 2'b00, ap};
      else
        got = {bx, by, bd, bh, bl, bdn, bc, be, bt, 2'b00, 13'd0, bp};
      n_checks++;
      if (e.due != cyc)
        $display("FAIL %s: checked late at cycle %0d, due %0d", nm, cyc, e.due);
      else if (got !== e.v)
        $display("FAIL %s: got %h expected %h", nm, got, e.v);
      else
        n_pass++;
    end
  end

  // Drive one cycle of commands on one instance; the other is held in reset.
  task automatic cmd(input logic sel, input logic rs, input logic av, input logic gi,
                     input logic [31:0] ev, input string nm);
    if (!sel) begin
      rst_a = rs; av_a = av; gi_a = gi;
      rst_b = 1'b1; av_b = 1'b0; gi_b = 1'b0;
    end else begin
      rst_b = rs; av_b = av; gi_b = gi;
      rst_a = 1'b1; av_a = 1'b0; gi_a = 1'b0;
    end
    exp_q.push_back('{sel: sel, due: cyc + 1, v: ev});
    name_q.push_back(nm);
    @(negedge clock);
  endtask

  logic [31:0] rv;
  logic [31:0] hold_v;
  int          hl_h[4] = '{0, 1, 1, 1};
  int          hl_l[4] = '{1, 0, 1, 1};

  initial begin
    rst_a = 1'b1; av_a = 1'b0; gi_a = 1'b0;
    rst_b = 1'b1; av_b = 1'b0; gi_b = 1'b0;
    rv = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clock);

    // ---------------- instance A ----------------
    cmd(0, 1, 0, 0, rv, "a_reset");
    for (int i = 1; i <= 7; i++)
      cmd(0, 0, 1, 0, mk(0, i, 0, (i == 7) ? 1 : 0, 1, 0, 0, 0, 0, i), $sformatf("a_fwd%0d", i));
    cmd(0, 0, 1, 0, mk(0, 7, 0, 1, 1, 0, 1, 0, 0, 7), "a_collide");
    cmd(0, 1, 0, 0, rv, "a_reset2");
    cmd(0, 0, 0, 1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1), "a_rot_e");
    cmd(0, 0, 0, 1, mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 2), "a_rot_s");
    cmd(0, 0, 0, 1, mk(0, 0, 3, 1, 1, 0, 0, 0, 0, 3), "a_rot_w");
    cmd(0, 0, 0, 1, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 4), "a_rot_n");
    cmd(0, 0, 1, 1, mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 4), "a_both");
    cmd(0, 0, 1, 0, mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 5), "a_erro_sticky_fwd");
    cmd(0, 0, 0, 1, mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 6), "a_erro_sticky_rot");
    cmd(0, 0, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 6), "a_idle");
    cmd(0, 1, 0, 1, rv, "a_reset_prio");

    // ---------------- instance B ----------------
    cmd(1, 1, 0, 0, rv, "b_reset");
    cmd(1, 0, 0, 1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1), "b_rot_e_wall");
    cmd(1, 0, 1, 0, mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1), "b_hit_wall");
    cmd(1, 0, 0, 1, mk(0, 0, 2, 1, 1, 0, 1, 0, 0, 2), "b_rot_s");
    cmd(1, 0, 0, 1, mk(0, 0, 3, 1, 1, 0, 1, 0, 0, 3), "b_rot_w");
    cmd(1, 0, 0, 1, mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 4), "b_rot_n");
    cmd(1, 0, 1, 0, mk(0, 1, 0, 0, 1, 0, 1, 0, TMO, 5), "b_fwd5");
    hold_v = TMO ? mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 5) : mk(0, 2, 0, 0, 1, 1, 1, 0, 0, 6);
    cmd(1, 0, 1, 0, hold_v, "b_fwd6");
    cmd(1, 0, 0, 1, hold_v, "b_frozen_rot");
    cmd(1, 1, 0, 0, rv, "b_reset2");
    cmd(1, 0, 1, 0, mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1), "b_goal_fwd1");
    cmd(1, 0, 1, 0, mk(0, 2, 0, 0, 1, 1, 0, 0, 0, 2), "b_goal_fwd2");
    cmd(1, 0, 1, 0, mk(0, 2, 0, 0, 1, 1, 0, 0, 0, 2), "b_done_fwd");
    cmd(1, 0, 0, 1, mk(0, 2, 0, 0, 1, 1, 0, 0, 0, 2), "b_done_rot");
    cmd(1, 1, 1, 0, rv, "b_reset_mid");
    for (int i = 1; i <= 9; i++) begin
      int p, d;
      if (TMO != 0) begin
        p = (i < 5) ? i : 5;
        d = p % 4;
      end else begin
        p = (i < 7) ? i : 7;
        d = i % 4;
      end
      cmd(1, 0, 0, 1, mk(0, 0, d, hl_h[d], hl_l[d], 0, 0, 0, (TMO != 0 && i >= 5) ? 1 : 0, p),
          $sformatf("b_rot_hold%0d", i));
    end

    rst_b = 1'b1; gi_b = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
